// File: rtl/h_rams_1r1w.sv
// One-read/one-write synchronous RAM model with masked writes,
// configurable read latency, collision semantics and zero-fill.
module h_rams_1r1w #(
  parameter int W      = 32,
  parameter int N      = 256,
  parameter int LAT    = 1,
  parameter int BYPASS = 0,
  parameter int INIT   = 1,
  localparam int AW    = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [W-1:0]  wmask,
  output logic          rvalid,
  output logic [W-1:0]  rdata,
  output logic          busy,
  output logic          err
);

  localparam logic [AW:0]   NN   = (AW+1)'(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic {FILL, READY} st_t;

  st_t           st;
  st_t           st_nx;
  logic [AW-1:0] cnt;
  logic [W-1:0]  mem [N];

  logic          rdy;
  logic          racc;
  logic          wacc;
  logic          rbad;
  logic          wbad;
  logic          wok;
  logic [W-1:0]  mw;
  logic [W-1:0]  rword;

  logic [LAT-1:0] pv;
  logic [W-1:0]   pd [LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) st <= (INIT != 0) ? FILL : READY;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      FILL:    if (cnt == LAST) st_nx = READY;
      READY:   st_nx = READY;
      default: st_nx = READY;
    endcase
  end

  always_comb begin
    busy = (st == FILL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (busy) cnt <= cnt + AW'(1);
  end

  // Requests only count in READY and never while reset is held.
  assign rdy  = rst_n & ~busy;
  assign racc = ren & rdy;
  assign wacc = wen & rdy;
  assign rbad = ({1'b0, raddr} >= NN);
  assign wbad = ({1'b0, waddr} >= NN);
  assign wok  = wacc & ~wbad;
  assign mw   = (mem[waddr] & ~wmask) | (wdata & wmask);

  always_comb begin
    rword = '0;
    if (!rbad) begin
      if (BYPASS != 0 && wok && waddr == raddr)
        rword = mw;
      else
        rword = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && busy)
      mem[cnt] <= '0;
    else if (wok)
      mem[waddr] <= mw;
  end

  // Data regs only advance behind a valid, so the tail holds rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv  <= '0;
      err <= 1'b0;
      for (int i = 0; i < LAT; i++)
        pd[i] <= '0;
    end else begin
      pv[0] <= racc;
      if (racc) pd[0] <= rword;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
      err <= (racc & rbad) | (wacc & wbad);
    end
  end

  assign rvalid = pv[LAT-1];
  assign rdata  = pd[LAT-1];

endmodule

// File: tb/tb_h_rams_1r1w.sv
// Directed bench: two RAM instances (LAT3/read-first and
// LAT1/write-first) share one stimulus stream.
module tb_h_rams_1r1w;

  logic       clk;
  logic       rst_n;
  logic       ren;
  logic [2:0] raddr;
  logic       wen;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [7:0] wmask;

  logic       rv0, bz0, er0;
  logic [7:0] rd0;
  logic       rv1, bz1, er1;
  logic [7:0] rd1;

  int npass;
  int ntot;

  h_rams_1r1w #(
    .W(8), .N(5), .LAT(3), .BYPASS(0), .INIT(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .ren(ren), .raddr(raddr),
    .wen(wen), .waddr(waddr),
    .wdata(wdata), .wmask(wmask),
    .rvalid(rv0), .rdata(rd0),
    .busy(bz0), .err(er0)
  );

  h_rams_1r1w #(
    .W(8), .N(5), .LAT(1), .BYPASS(1), .INIT(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .ren(ren), .raddr(raddr),
    .wen(wen), .waddr(waddr),
    .wdata(wdata), .wmask(wmask),
    .rvalid(rv1), .rdata(rd1),
    .busy(bz1), .err(er1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    ren = 1'b0;
    wen = 1'b0;
  endtask

  initial begin
    logic [7:0] e0 [4];
    logic [7:0] e1 [4];
    logic [7:0] em [5];
    npass = 0;
    ntot  = 0;
    rst_n = 1'b0;
    ren   = 1'b0;
    raddr = '0;
    wen   = 1'b0;
    waddr = '0;
    wdata = '0;
    wmask = '0;

    tick();
    tick();
    chk("rst_rv0", rv0, 0);
    chk("rst_rv1", rv1, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_er0", er0, 0);
    chk("rst_er1", er1, 0);
    chk("rst_bz0", bz0, 1);
    chk("rst_bz1", bz1, 1);

    // fill: requests (out of range too) dropped silently
    rst_n = 1'b1;
    ren   = 1'b1;
    raddr = 3'd6;
    wen   = 1'b1;
    waddr = 3'd7;
    wmask = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      chk("fill_bz0", bz0, 1);
      chk("fill_bz1", bz1, 1);
      chk("fill_rv0", rv0, 0);
      chk("fill_rv1", rv1, 0);
      chk("fill_er0", er0, 0);
      chk("fill_er1", er1, 0);
      if (i == 4) idle();
      tick();
    end
    chk("ready_bz0", bz0, 0);
    chk("ready_bz1", bz1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("drop_rv0", rv0, 0);
      chk("drop_rv1", rv1, 0);
      chk("drop_er0", er0, 0);
      chk("drop_er1", er1, 0);
      tick();
    end

    // read back zero-filled words
    for (int i = 0; i < 8; i++) begin
      ren   = (i < 5);
      raddr = 3'(i);
      tick();
      chk("zrd_rv1", rv1, (i < 5) ? 1 : 0);
      chk("zrd_rv0", rv0, (i >= 2 && i < 7) ? 1 : 0);
      chk("zrd_rd1", rd1, 0);
      chk("zrd_rd0", rd0, 0);
    end
    idle();

    // masked merge
    wen   = 1'b1;
    waddr = 3'd2;
    wdata = 8'hFF;
    wmask = 8'hFF;
    tick();
    wdata = 8'h0F;
    wmask = 8'h3C;
    tick();
    wen   = 1'b0;
    ren   = 1'b1;
    raddr = 3'd2;
    tick();
    ren = 1'b0;
    chk("mask_rv1", rv1, 1);
    chk("mask_rd1", rd1, 8'hCF);
    tick();
    chk("mask_rv1_lo", rv1, 0);
    chk("mask_rd1_hold", rd1, 8'hCF);
    chk("mask_rv0_lo", rv0, 0);
    tick();
    chk("mask_rv0", rv0, 1);
    chk("mask_rd0", rd0, 8'hCF);
    tick();
    chk("mask_rv0_lo2", rv0, 0);
    chk("mask_rd0_hold", rd0, 8'hCF);

    // collision
    wen   = 1'b1;
    waddr = 3'd3;
    wdata = 8'h11;
    wmask = 8'hFF;
    tick();
    ren   = 1'b1;
    raddr = 3'd3;
    wdata = 8'h22;
    tick();
    chk("col_rv1", rv1, 1);
    chk("col_rd1", rd1, 8'h22);
    wen = 1'b0;
    tick();
    ren = 1'b0;
    chk("col_next_rd1", rd1, 8'h22);
    tick();
    chk("col_rv0", rv0, 1);
    chk("col_rd0", rd0, 8'h11);
    tick();
    chk("col_next_rv0", rv0, 1);
    chk("col_next_rd0", rd0, 8'h22);
    tick();

    // throughput with a write racing the addr-1 read
    wmask = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      wen   = 1'b1;
      waddr = 3'(i);
      wdata = 8'hA0 + 8'(i);
      tick();
    end
    idle();
    e0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    e1 = '{8'hA0, 8'h55, 8'hA2, 8'hA3};
    for (int i = 0; i < 7; i++) begin
      ren   = (i < 4);
      raddr = 3'(i);
      wen   = (i == 1);
      waddr = 3'd1;
      wdata = 8'h55;
      tick();
      chk("thr_rv1", rv1, (i < 4) ? 1 : 0);
      if (i < 4) chk("thr_rd1", rd1, e1[i]);
      chk("thr_rv0", rv0, (i >= 2 && i <= 5) ? 1 : 0);
      if (i >= 2 && i <= 5) chk("thr_rd0", rd0, e0[i-2]);
    end
    idle();

    // range errors
    ren   = 1'b1;
    raddr = 3'd6;
    tick();
    ren = 1'b0;
    chk("rng_r_er0", er0, 1);
    chk("rng_r_er1", er1, 1);
    chk("rng_r_rv1", rv1, 1);
    chk("rng_r_rd1", rd1, 0);
    tick();
    chk("rng_r_er0_lo", er0, 0);
    chk("rng_r_er1_lo", er1, 0);
    tick();
    chk("rng_r_rv0", rv0, 1);
    chk("rng_r_rd0", rd0, 0);
    wen   = 1'b1;
    waddr = 3'd7;
    wdata = 8'hEE;
    tick();
    wen = 1'b0;
    chk("rng_w_er0", er0, 1);
    chk("rng_w_er1", er1, 1);
    tick();
    chk("rng_w_er0_lo", er0, 0);
    chk("rng_w_er1_lo", er1, 0);
    em = '{8'hA0, 8'h55, 8'hA2, 8'hA3, 8'h00};
    for (int i = 0; i < 8; i++) begin
      ren   = (i < 5);
      raddr = 3'(i);
      tick();
      if (i < 5) chk("rng_chk_rd1", rd1, em[i]);
      if (i >= 2 && i < 7) chk("rng_chk_rd0", rd0, em[i-2]);
      chk("rng_chk_rv0", rv0, (i >= 2 && i < 7) ? 1 : 0);
    end
    idle();

    // reset with reads in flight
    ren   = 1'b1;
    raddr = 3'd0;
    tick();
    chk("sq_rv1_a", rv1, 1);
    chk("sq_rd1_a", rd1, 8'hA0);
    raddr = 3'd1;
    tick();
    chk("sq_rv1_b", rv1, 1);
    chk("sq_rd1_b", rd1, 8'h55);
    ren   = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("sq_rv0", rv0, 0);
    chk("sq_rv1", rv1, 0);
    chk("sq_rd1_rst", rd1, 0);
    chk("sq_rd0_rst", rd0, 0);
    chk("sq_bz0", bz0, 1);

    // reset again at fill cycle 2
    rst_n = 1'b1;
    tick();
    chk("sq_rv0_late", rv0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_bz0", bz0, 1);
    chk("mid_rv0", rv0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("refill_bz0", bz0, 1);
      chk("refill_bz1", bz1, 1);
      tick();
    end
    chk("refill_done0", bz0, 0);
    chk("refill_done1", bz1, 0);
    ren   = 1'b1;
    raddr = 3'd3;
    tick();
    ren = 1'b0;
    chk("refill_rv1", rv1, 1);
    chk("refill_rd1", rd1, 0);
    tick();
    tick();
    chk("refill_rv0", rv0, 1);
    chk("refill_rd0", rd0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
